// File: rtl/irq_priority_controller_pkg.sv
// Shared constants for the interrupt priority controller.
// No logic, no latency.
// No flow control.
package irq_ctrl_pkg;

    localparam int N_SRC = 8;
    localparam int ID_W  = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_REQ  = 2'b01;
    localparam state_t ST_SERV = 2'b10;

endpackage

// File: rtl/irq_priority_controller_if.sv
// Request, mask and CPU-side irq/ack/eoi bundle for the interrupt controller.
// No logic, no latency.
// The irq/ack handshake is the backpressure; irq stays up until ack or withdrawal.
interface irq_priority_controller_if;
    import irq_ctrl_pkg::*;

    logic              en;
    logic [N_SRC-1:0]  irq_in;
    logic              mask_wr;
    logic [N_SRC-1:0]  mask_data;
    logic              ack;
    logic              eoi;
    logic              irq;
    logic [ID_W-1:0]   irq_id;
    logic              busy;
    logic [N_SRC-1:0]  pending_o;

    modport master (
        output en, irq_in, mask_wr, mask_data, ack, eoi,
        input  irq, irq_id, busy, pending_o
    );

    modport slave (
        input  en, irq_in, mask_wr, mask_data, ack, eoi,
        output irq, irq_id, busy, pending_o
    );

endinterface

// File: rtl/irq_priority_controller_prio_enc.sv
// 8-to-3 fixed-priority encoder, highest index wins, with an any-valid flag.
// Purely combinational, zero latency.
// No flow control.
module prio_enc_8
    import irq_ctrl_pkg::*;
(
    input  logic [N_SRC-1:0] vec,
    output logic [ID_W-1:0]  idx,
    output logic             vld
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (vec[i]) idx = ID_W'(i);
        end
    end

    assign vld = |vec;

endmodule

// File: rtl/irq_priority_controller.sv
// Sticky-pending, masked, fixed-priority interrupt sequencer (IRQ_EDGE_DETECT_EN: edge capture).
// Latency: request edge t -> pending after t -> irq after t+1.
// irq is held until ack; withdrawn if disabled, masked or no longer pending.
module irq_priority_controller
    import irq_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    irq_priority_controller_if.slave  bus
);

    state_t            state, state_nxt;
    logic [N_SRC-1:0]  pending, mask, pend_set, pend_clr, eligible;
    logic [ID_W-1:0]   winner, irq_id_nxt;
    logic              winner_vld, irq_nxt, busy_nxt;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N_SRC-1:0]  irq_in_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_in_d <= '0;
        else        irq_in_d <= bus.irq_in;
    end

    assign pend_set = bus.irq_in & ~irq_in_d;
`else
    assign pend_set = bus.irq_in;
`endif

    always_comb begin
        pend_clr = '0;
        if (state == ST_REQ && bus.ack) pend_clr[bus.irq_id] = 1'b1;
    end

    // Set is OR'ed after the clear so a same-cycle re-request survives the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
            if (bus.mask_wr) mask <= bus.mask_data;
        end
    end

    assign eligible = pending & ~mask;

    prio_enc_8 u_prio_enc (
        .vec (eligible),
        .idx (winner),
        .vld (winner_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bus.irq    <= 1'b0;
            bus.irq_id <= '0;
            bus.busy   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bus.irq    <= irq_nxt;
            bus.irq_id <= irq_id_nxt;
            bus.busy   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.en && winner_vld) state_nxt = ST_REQ;
            ST_REQ: begin
                if (bus.ack)
                    state_nxt = ST_SERV;
                else if (!bus.en || mask[bus.irq_id] || !pending[bus.irq_id])
                    state_nxt = ST_IDLE;
            end
            ST_SERV: if (bus.eoi) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the transition taken.
    always_comb begin
        irq_nxt    = 1'b0;
        busy_nxt   = 1'b0;
        irq_id_nxt = bus.irq_id;
        case (state_nxt)
            ST_REQ:  irq_nxt  = 1'b1;
            ST_SERV: busy_nxt = 1'b1;
            default: ;
        endcase
        if (state == ST_IDLE && state_nxt == ST_REQ) irq_id_nxt = winner;
    end

    assign bus.pending_o = pending;

endmodule
